// File: rtl/ram_loader.sv
// Streams a length-prefixed, checksummed byte packet into an 8-bit-addressed RAM.
// Define RAM_LOADER_VERIFY_EN to add a readback pass that re-sums RAM before reporting done.
module ram_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ram_we,
  output logic       ram_cs,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cpu_halt
);

  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
`ifdef RAM_LOADER_VERIFY_EN
    StVerify,
`endif
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [8:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              we_q, we_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              xfer;
  logic              verifying;

`ifdef RAM_LOADER_VERIFY_EN
  logic [7:0] vsum_q, vsum_d;
  assign verifying = (state_q == StVerify);
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign verifying = 1'b0;
`endif

  assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign xfer     = in_ready && in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    stall_d = stall_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef RAM_LOADER_VERIFY_EN
    vsum_d  = vsum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = 9'd0;
          csum_d  = 8'd0;
          stall_d = '0;
          addr_d  = 8'd0;
        end
      end
      StLen, StData, StCsum: begin
        if (xfer) begin
          stall_d = '0;
          if (state_q == StLen) begin
            // A zero length byte encodes a full 256-byte payload.
            len_d   = {in_data == 8'd0, in_data};
            cnt_d   = 9'd0;
            state_d = StData;
          end else if (state_q == StData) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[7:0];
            wdata_d = in_data;
            csum_d  = csum_q + in_data;
            cnt_d   = cnt_q + 9'd1;
            if (cnt_q == len_q - 9'd1) state_d = StCsum;
          end else if (in_data == csum_q) begin
`ifdef RAM_LOADER_VERIFY_EN
            state_d = StVerify;
            addr_d  = 8'd0;
            cnt_d   = 9'd0;
            vsum_d  = 8'd0;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StErr;
          end
        end else if (stall_q == StallMax) begin
          state_d = StErr;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      StVerify: begin
        vsum_d = vsum_q + ram_rdata;
        addr_d = addr_q + 8'd1;
        cnt_d  = cnt_q + 9'd1;
        if (cnt_q == len_q - 9'd1) state_d = (vsum_d == csum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 9'd0;
      len_q   <= 9'd0;
      csum_q  <= 8'd0;
      stall_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
`ifdef RAM_LOADER_VERIFY_EN
      vsum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef RAM_LOADER_VERIFY_EN
      vsum_q  <= vsum_d;
`endif
    end
  end

  assign ram_we    = we_q;
  assign ram_cs    = we_q || verifying;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = in_ready || verifying;
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);
  assign cpu_halt  = (state_q != StDone);

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboarded bench for ram_loader: expected RAM writes are queued as bytes are sent and
// popped as the DUT writes. Honours RAM_LOADER_VERIFY_EN for the readback scenarios.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready;
  logic [7:0] in_data, ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, ram_cs, busy, done, error, cpu_halt;

  always #5 clk = ~clk;

  ram_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_cs   (ram_cs),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_halt (cpu_halt)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] mem [256];
  logic [7:0] pay [256];
  logic       corrupt, mem_clr;
  int         n_cmp, n_bad, cyc, wr_cnt, first_wr, last_wr;
  logic [7:0] last_addr;

  assign ram_rdata = (corrupt && ram_addr == 8'd1) ? 8'h00 : mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // RAM model plus write monitor, sampled on the negedge when the RAM commits.
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      check("wr_cs", ram_cs, 1);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", ram_addr, mon_e.a);
        check("wr_data", ram_wdata, mon_e.d);
      end
      if (wr_cnt == 0) first_wr = cyc;
      last_wr   = cyc;
      last_addr = ram_addr;
      wr_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    tick();
  endtask

  task automatic stream(input logic [7:0] lenb, input int n, input logic [7:0] csb);
    send(lenb);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(wr_t'{a: 8'(k), d: pay[k]});
      send(pay[k]);
    end
    send(csb);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input int exp_lat);
    int n = 0;
    while (!(done || error) && n < 600) begin
      tick();
      n++;
    end
    check("latency", n, exp_lat);
  endtask

  task automatic clear_mem;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; wr_cnt = 0; first_wr = 0; last_wr = 0; last_addr = 8'h00;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    corrupt = 1'b0; mem_clr = 1'b0;
    clear_mem();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_halt", cpu_halt, 1);
    rst_n = 1'b1;
    tick();

    // Good 3-byte packet streamed without gaps.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    wr_cnt = 0;
    do_start();
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    stream(8'h03, 3, 8'h66);
    wait_end(VerifyEn ? 3 : 0);
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_cpu_halt", cpu_halt, 0);
    check("t1_wr_cnt", wr_cnt, 3);
    check("t1_b2b", last_wr - first_wr, 2);
    check("t1_queue", 32'(exp_q.size()), 0);

    // Same packet with a bad checksum.
    clear_mem();
    wr_cnt = 0;
    do_start();
    check("t2_done_cleared", done, 0);
    stream(8'h03, 3, 8'h67);
    wait_end(0);
    check("t2_error", error, 1);
    check("t2_done", done, 0);
    check("t2_cpu_halt", cpu_halt, 1);
    check("t2_mem0", mem[0], 8'h11);
    check("t2_mem1", mem[1], 8'h22);
    check("t2_mem2", mem[2], 8'h33);
    check("t2_wr_cnt", wr_cnt, 3);

    // Length 0 means 256 bytes; sum of 00..FF is 0x7F80.
    for (int k = 0; k < 256; k++) pay[k] = 8'(k);
    wr_cnt = 0;
    do_start();
    check("t3_error_cleared", error, 0);
    stream(8'h00, 256, 8'h80);
    wait_end(VerifyEn ? 256 : 0);
    check("t3_done", done, 1);
    check("t3_wr_cnt", wr_cnt, 256);
    check("t3_last_addr", last_addr, 8'hff);
    check("t3_b2b", last_wr - first_wr, 255);
    check("t3_mem_ff", mem[255], 8'hff);
    check("t3_queue", 32'(exp_q.size()), 0);

    // Stall timeout after the length byte: 7 idle cycles survive, the 8th errors.
    wr_cnt = 0;
    do_start();
    send(8'h03);
    in_valid = 1'b0;
    repeat (7) tick();
    check("t4_err_early", error, 0);
    check("t4_busy_early", busy, 1);
    tick();
    check("t4_error", error, 1);
    check("t4_busy", busy, 0);
    check("t4_wr_cnt", wr_cnt, 0);

    // Reset after the second payload byte has been accepted.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    wr_cnt = 0;
    do_start();
    send(8'h03);
    exp_q.push_back(wr_t'{a: 8'h00, d: pay[0]});
    exp_q.push_back(wr_t'{a: 8'h01, d: pay[1]});
    send(pay[0]);
    send(pay[1]);
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    check("t5_ram_we", ram_we, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_error", error, 0);
    check("t5_cpu_halt", cpu_halt, 1);
    check("t5_ram_addr", ram_addr, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_wr_cnt", wr_cnt, 2);
    check("t5_queue", 32'(exp_q.size()), 0);

    // Reset on the same edge as the second byte: that byte never reaches RAM.
    wr_cnt = 0;
    do_start();
    send(8'h03);
    exp_q.push_back(wr_t'{a: 8'h00, d: pay[0]});
    send(pay[0]);
    in_valid = 1'b1;
    in_data  = pay[1];
    rst_n    = 1'b0;
    tick();
    check("t6_ram_we", ram_we, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    check("t6_wr_cnt", wr_cnt, 1);
    check("t6_queue", 32'(exp_q.size()), 0);

`ifdef RAM_LOADER_VERIFY_EN
    // Readback sees address 1 corrupted to 00, so the verify sum mismatches.
    corrupt = 1'b1;
    wr_cnt  = 0;
    do_start();
    stream(8'h03, 3, 8'h66);
    for (int i = 0; i < 3; i++) begin
      check("t7_busy", busy, 1);
      check("t7_ram_cs", ram_cs, 1);
      check("t7_ram_we", ram_we, 0);
      check("t7_ram_addr", ram_addr, i);
      tick();
    end
    check("t7_error", error, 1);
    check("t7_done", done, 0);
    check("t7_cpu_halt", cpu_halt, 1);
    corrupt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the max stall cycles waiting for an input byte before error.
REQ-002 SHALL have one clock; reset is synchronous and active-low: clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have in_valid  input  1  input byte valid.
REQ-006 SHALL have in_data  input  8  input byte (length, payload, checksum).
REQ-007 SHALL have in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have ram_we  output  1  RAM write enable.
REQ-009 SHALL have ram_cs  output  1  RAM chip select; high whenever ram_we is high or a readback is in progress.
REQ-010 SHALL have ram_addr  output  8  RAM address.
REQ-011 SHALL have ram_wdata  output  8  RAM write data.
REQ-012 SHALL have ram_rdata  input  8  RAM asynchronous read data for ram_addr.
REQ-013 SHALL have busy, done, error, cpu_halt  output  1 each  status (meanings below).

Function
REQ-014 SHALL implement states IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERR.
REQ-015 A byte transfer SHALL occur exactly on a posedge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LEN, DATA and CSUM.
REQ-016 IDLE/DONE/ERR + start=1 -> LEN; clears the address counter, byte count, running checksum, done and error; start in any other state is ignored.
REQ-017 LEN: the accepted byte gives N (0 means 256); next state DATA.
REQ-018 DATA: the k-th accepted byte (k=0..N-1) SHALL be written at address k; after byte N-1, next state CSUM.
REQ-019 Each write SHALL be registered: the cycle after acceptance, ram_we=1, ram_addr=k and ram_wdata=byte for exactly one cycle, so the RAM commits on that cycle's negedge.
REQ-020 Back-to-back accepts SHALL produce back-to-back write cycles, with a throughput of 1 byte per cycle.
REQ-021 The running checksum SHALL be the 8-bit modulo-256 sum of the payload bytes only; the length byte is excluded.
REQ-022 CSUM: if the accepted byte equals the checksum -> VERIFY (macro on) or DONE (macro off); otherwise -> ERR.
REQ-023 Timeout: in LEN, DATA or CSUM, TIMEOUT_CYCLES consecutive cycles with in_valid=0 -> ERR; any transfer SHALL reset the stall counter.
REQ-024 The byte counter SHALL be 9 bits to handle N=256; the address SHALL wrap from 255 to 0 only after the final write, and no address outside 0..N-1 is ever written.
REQ-025 busy=1 in LEN, DATA, CSUM and VERIFY; done=1 in DONE; error=1 in ERR; done and error SHALL hold until the next start.
REQ-026 cpu_halt SHALL be 1 in every state except DONE.
REQ-027 ram_we SHALL be 0 in every cycle that does not follow a DATA acceptance, including the cycle after the final write.

Reset
REQ-028 rst_n=0 at a posedge SHALL force IDLE, with in_ready=0, ram_we=0, ram_cs=0, ram_addr=0, ram_wdata=0, busy=0, done=0, error=0, cpu_halt=1, and counters and checksum cleared.
REQ-029 Reset mid-load SHALL abort with no further write; a write already registered for that cycle SHALL be cancelled (ram_we=0 from that edge).

Configuration
REQ-030 The macro RAM_LOADER_VERIFY_EN, when defined, SHALL enable the VERIFY state: ram_addr steps 0..N-1 one per cycle with ram_cs=1 and ram_we=0, and ram_rdata is summed at each posedge.
REQ-031 With the macro defined, a readback sum equal to the received checksum -> DONE, otherwise -> ERR; this adds N cycles of latency.
REQ-032 Without the macro, the VERIFY state and its logic SHALL be absent, and CSUM match -> DONE directly.

Verification
REQ-033 The bench SHALL cover: reset, then start, then bytes 03, 11, 22, 33, 66 streamed continuously -> writes at addresses 0/1/2 with data 11/22/33 on consecutive cycles, then done=1 and cpu_halt=0.
REQ-034 The bench SHALL cover: the same stream with checksum 67 -> error=1, done=0, cpu_halt=1, and RAM addresses 0..2 still written.
REQ-035 The bench SHALL cover: length 00 with payload 00..FF and checksum 80 -> 256 writes, with the last write at address FF, then done=1.
REQ-036 The bench SHALL cover: TIMEOUT_CYCLES=8, and in_valid held low for 8 cycles after the length byte -> error=1 with no write issued.
REQ-037 The bench SHALL cover: rst_n=0 asserted after the 2nd payload byte -> ram_we=0 from that edge, state IDLE, and cpu_halt=1.
REQ-038 The bench SHALL cover, with RAM_LOADER_VERIFY_EN defined: a RAM model corrupting address 1 to 00 -> VERIFY runs 3 cycles, then error=1.
